// File: rtl/fp_pkg.sv
// Shared floating-point definitions: flag width, flag bit positions and the
// flag/result entry types used by the multiplier result buffer.
package fp_pkg;

  localparam int FLAG_W = 3;
  localparam int EXC    = 2;
  localparam int OVF    = 1;
  localparam int UNF    = 0;

  typedef logic [FLAG_W-1:0] fp_flags_t;

  typedef struct packed {
    logic [31:0] result;
    fp_flags_t   flags;
  } fp_entry_t;

endpackage

// File: rtl/fp_sync_fifo.sv
// Synchronous FIFO of fp_entry_t words; a push is accepted when not full or
// when a pop frees a slot in the same cycle. Storage itself is not reset.
module fp_sync_fifo
  import fp_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  fp_entry_t     wdata_i,
  output fp_entry_t     rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          push_ok_o
);

  fp_entry_t mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;
  logic          push_ok;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(DEPTH));
  assign pop_ok    = pop_i & ~empty_o;
  assign push_ok   = push_i & (~full_o | pop_ok);
  assign push_ok_o = push_ok;
  assign count_o   = count_q;
  assign rdata_o   = mem[rd_ptr_q];

  // DEPTH is a power of two, so pointer wrap is the natural PW-bit overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fp_result_buffer.sv
// Result buffer behind the FP multiplier: FIFO of {result, flags}, drop pulse on
// overflowing input, optional sticky flags (macro FP_RESULT_BUF_STICKY_EN).
module fp_result_buffer
  import fp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [31:0]            in_result,
  input  logic [FLAG_W-1:0]      in_flags,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_result,
  output logic [FLAG_W-1:0]      out_flags,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   drop,
  input  logic                   sticky_clear,
  output logic [FLAG_W-1:0]      sticky_flags
);

  // Handshake: the head transfers on a cycle where out_valid and out_ready are
  // both high; in_valid has no back-pressure, a word that finds no room is lost.
  fp_entry_t wdata;
  fp_entry_t rdata;
  logic      empty;
  logic      push_ok;
  logic      drop_q, drop_d;

  assign wdata.result = in_result;
  assign wdata.flags  = in_flags;

  fp_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push_i    (in_valid),
    .pop_i     (out_ready),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty),
    .push_ok_o (push_ok)
  );

  assign out_valid  = ~empty;
  assign out_result = rdata.result;
  assign out_flags  = rdata.flags;

  assign drop_d = in_valid & ~push_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_q <= 1'b0;
    else        drop_q <= drop_d;
  end

  assign drop = drop_q;

`ifdef FP_RESULT_BUF_STICKY_EN
  fp_flags_t sticky_q, sticky_d;
  fp_flags_t acc_flags;

  // A clear coinciding with an accepted push keeps only that word's flags.
  assign acc_flags = push_ok ? in_flags : '0;

  always_comb begin
    sticky_d = sticky_q | acc_flags;
    if (sticky_clear) sticky_d = acc_flags;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_sticky_clear;
  assign unused_sticky_clear = sticky_clear;
  assign sticky_flags        = '0;
`endif

endmodule

// File: tb/tb_fp_result_buffer.sv
// Directed plus random bench for fp_result_buffer with an expected-entry queue.
module tb_fp_result_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [31:0]   in_result;
  logic [2:0]    in_flags;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  logic [2:0]    out_flags;
  logic [CW-1:0] count;
  logic          full;
  logic          drop;
  logic          sticky_clear;
  logic [2:0]    sticky_flags;

  logic [34:0] exp_q[$];
  logic        exp_drop;
  logic [2:0]  exp_sticky;
  int          checks;
  int          failures;

  fp_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .count        (count),
    .full         (full),
    .drop         (drop),
    .sticky_clear (sticky_clear),
    .sticky_flags (sticky_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 64'(count), 64'(exp_q.size()));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(exp_q.size() != 0));
    check({tag, "_full"}, 64'(full), 64'(exp_q.size() == DEPTH));
    check({tag, "_drop"}, 64'(drop), 64'(exp_drop));
    check({tag, "_sticky"}, 64'(sticky_flags), 64'(exp_sticky));
    if (exp_q.size() != 0) check({tag, "_head"}, 64'({out_result, out_flags}), 64'(exp_q[0]));
  endtask

  // Drive one cycle of inputs, update the model at the edge, check after it.
  task automatic cycle(input string tag, input logic v, input logic [31:0] res,
                       input logic [2:0] fl, input logic rdy, input logic clr);
    logic        pop;
    logic        push;
    logic [34:0] head;
    in_valid     = v;
    in_result    = res;
    in_flags     = fl;
    out_ready    = rdy;
    sticky_clear = clr;
    pop  = rdy && (exp_q.size() != 0);
    push = v && ((exp_q.size() < DEPTH) || pop);
    if (pop) begin
      head = exp_q.pop_front();
      check({tag, "_pop_data"}, 64'({out_result, out_flags}), 64'(head));
    end
    if (push) exp_q.push_back({res, fl});
    exp_drop = v && !push;
`ifdef FP_RESULT_BUF_STICKY_EN
    if (clr) exp_sticky = push ? fl : 3'b000;
    else if (push) exp_sticky = exp_sticky | fl;
`endif
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    sticky_clear = 1'b0;
    check_state(tag);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    exp_drop     = 1'b0;
    exp_sticky   = 3'b000;
    reset        = 1'b0;
    in_valid     = 1'b0;
    in_result    = '0;
    in_flags     = '0;
    out_ready    = 1'b0;
    sticky_clear = 1'b0;
    #1;
    check_state("reset");
    #11;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_state("post_reset");

    cycle("first_push", 1'b1, 32'h4040_0000, 3'b000, 1'b0, 1'b0);
    cycle("hold_idle", 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    cycle("push2", 1'b1, 32'h4000_0000, 3'b001, 1'b0, 1'b0);
    cycle("push3", 1'b1, 32'h4080_0000, 3'b010, 1'b0, 1'b0);
    cycle("push4_full", 1'b1, 32'h40A0_0000, 3'b100, 1'b0, 1'b0);
    cycle("push5_drop", 1'b1, 32'hDEAD_BEEF, 3'b111, 1'b0, 1'b0);
    cycle("after_drop", 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    cycle("full_push_pop", 1'b1, 32'h3F80_0000, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    cycle("ready_empty", 1'b0, 32'h0, 3'b000, 1'b1, 1'b0);

    cycle("one_push", 1'b1, 32'h1111_1111, 3'b000, 1'b0, 1'b0);
    cycle("one_push_pop", 1'b1, 32'h2222_2222, 3'b001, 1'b1, 1'b0);
    cycle("one_pop", 1'b0, 32'h0, 3'b000, 1'b1, 1'b0);

    cycle("sticky_exc", 1'b1, 32'h5000_0000, 3'b100, 1'b1, 1'b0);
    cycle("sticky_unf", 1'b1, 32'h5100_0000, 3'b001, 1'b1, 1'b0);
    cycle("sticky_clr_push", 1'b1, 32'h5200_0000, 3'b010, 1'b1, 1'b1);
    cycle("sticky_all", 1'b1, 32'h5300_0000, 3'b111, 1'b1, 1'b0);
    cycle("sticky_clr", 1'b0, 32'h0, 3'b000, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle("drain2", 1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle("fill_flags", 1'b1, 32'h6000_0000 + 32'(i), 3'b000, 1'b0, 1'b0);
    cycle("drop_no_sticky", 1'b1, 32'h6FFF_FFFF, 3'b111, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end

    for (int i = 0; i < DEPTH + 1; i++) cycle("drain3", 1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("fill3", 1'b1, 32'h7000_0000 + 32'(i), 3'b011, 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    exp_q.delete();
    exp_drop   = 1'b0;
    exp_sticky = 3'b000;
    check_state("mid_reset");
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_state("after_release");
    cycle("push_after_reset", 1'b1, 32'h4248_0000, 3'b000, 1'b0, 1'b0);
    cycle("final_pop", 1'b0, 32'h0, 3'b000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
